// File: rtl/stm32_iq_link.sv
// -----------------------------------------------------------------------------
// stm32_iq_link
//
// Byte-wide command/data link between an STM32 MCU and the FPGA IQ datapath.
// A DATA_SYNC strobe carries a command byte. The command selects one of:
//   0x00 bus echo test, 0x03 TX IQ receive, 0x04 RX IQ stream,
//   0x09 set RX channel mask, 0x0A status readout.
// Any other code returns the link to IDLE.
//
// Ports
//   clk_in        single clock for all logic
//   reset_n       synchronous, active-low reset
//   DATA_SYNC     command strobe (DATA_BUS_IN holds the command byte)
//   DATA_BUS_IN   MCU -> FPGA byte
//   DATA_BUS_OUT  FPGA -> MCU byte (registered)
//   DATA_BUS_OE   1 = FPGA drives the bus (tristate buffer lives at top level)
//   RX_I, RX_Q    packed signed RX samples, channel 0 in the LSBs
//   rx_valid      one-cycle strobe, a new RX sample set is present
//   TX_I, TX_Q    signed TX samples assembled from the MCU bytes
//   tx_iq_valid   one-cycle pulse when TX_I/TX_Q update
//   iq_overrun    sticky RX overrun flag
//   state_debug   current FSM state encoding
//
// State encoding (state_debug):
//   0 IDLE, 1 TEST_RD, 2 TEST_WR, 3 TX_RCV, 4 RX_STREAM, 5 SET_MASK, 6 STATUS
//
// Output timing: DATA_BUS_OUT is computed one cycle ahead. The byte that
// belongs to a state cycle is therefore already on the bus during that cycle.
// For example, the first RX byte is visible in the first RX_STREAM cycle,
// and status byte 0 in the first STATUS cycle.
// -----------------------------------------------------------------------------
module stm32_iq_link #(
  parameter int NUM_RX       = 2,
  parameter int SAMPLE_BYTES = 3
) (
  input  logic                             clk_in,
  input  logic                             reset_n,
  input  logic                             DATA_SYNC,
  input  logic [7:0]                       DATA_BUS_IN,
  output logic [7:0]                       DATA_BUS_OUT,
  output logic                             DATA_BUS_OE,
  input  logic [NUM_RX*8*SAMPLE_BYTES-1:0] RX_I,
  input  logic [NUM_RX*8*SAMPLE_BYTES-1:0] RX_Q,
  input  logic                             rx_valid,
  output logic [8*SAMPLE_BYTES-1:0]        TX_I,
  output logic [8*SAMPLE_BYTES-1:0]        TX_Q,
  output logic                             tx_iq_valid,
  output logic                             iq_overrun,
  output logic [3:0]                       state_debug
);

  localparam int SW = 8 * SAMPLE_BYTES;
  localparam int NB = 2 * SAMPLE_BYTES;            // bytes per channel (Q + I)
  localparam logic [2:0] IDX_LAST = 3'(NB - 1);
  localparam logic [NUM_RX-1:0] MASK_ONE = NUM_RX'(1);
  localparam logic [3:0] NRX4 = 4'(NUM_RX);
  localparam logic [3:0] SB4  = 4'(SAMPLE_BYTES);

  localparam logic [7:0] CMD_TEST   = 8'h00;
  localparam logic [7:0] CMD_TX     = 8'h03;
  localparam logic [7:0] CMD_RX     = 8'h04;
  localparam logic [7:0] CMD_MASK   = 8'h09;
  localparam logic [7:0] CMD_STATUS = 8'h0A;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_TEST_RD   = 4'd1,
    S_TEST_WR   = 4'd2,
    S_TX_RCV    = 4'd3,
    S_RX_STREAM = 4'd4,
    S_SET_MASK  = 4'd5,
    S_STATUS    = 4'd6
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic state_t decode_cmd(input logic [7:0] c);
    state_t s;
    case (c)
      CMD_TEST:   s = S_TEST_RD;
      CMD_TX:     s = S_TX_RCV;
      CMD_RX:     s = S_RX_STREAM;
      CMD_MASK:   s = S_SET_MASK;
      CMD_STATUS: s = S_STATUS;
      default:    s = S_IDLE;
    endcase
    return s;
  endfunction

  // Lowest enabled channel.
  function automatic logic [1:0] first_en(input logic [NUM_RX-1:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int c = NUM_RX - 1; c >= 0; c--) begin
      if (m[c]) r = 2'(c);
    end
    return r;
  endfunction

  // Next enabled channel above ch, wrapping to the lowest enabled one.
  function automatic logic [1:0] next_en(input logic [NUM_RX-1:0] m, input logic [1:0] ch);
    logic [1:0] r;
    logic       found;
    r     = first_en(m);
    found = 1'b0;
    for (int c = 0; c < NUM_RX; c++) begin
      if (!found && m[c] && (2'(c) > ch)) begin
        r     = 2'(c);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // True when no enabled channel lies above ch.
  function automatic logic is_last(input logic [NUM_RX-1:0] m, input logic [1:0] ch);
    logic last;
    last = 1'b1;
    for (int c = 0; c < NUM_RX; c++) begin
      if (m[c] && (2'(c) > ch)) last = 1'b0;
    end
    return last;
  endfunction

  // Byte b (0..NB-1) of channel ch in frame order: Q then I, MSB first.
  function automatic logic [7:0] pick_byte(input logic [NUM_RX*SW-1:0] iv,
                                           input logic [NUM_RX*SW-1:0] qv,
                                           input logic [1:0]           ch,
                                           input logic [2:0]           b);
    logic [SW-1:0] s;
    logic [7:0]    r;
    int            pos;
    s = '0;
    r = '0;
    for (int c = 0; c < NUM_RX; c++) begin
      if (ch == 2'(c)) s = (int'(b) < SAMPLE_BYTES) ? qv[c*SW +: SW] : iv[c*SW +: SW];
    end
    pos = (int'(b) < SAMPLE_BYTES) ? (SAMPLE_BYTES - 1 - int'(b)) : (NB - 1 - int'(b));
    for (int k = 0; k < SAMPLE_BYTES; k++) begin
      if (pos == k) r = s[k*8 +: 8];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                  state_reg, state_next;
  logic [7:0]              data_out_reg, data_out_next;
  logic                    oe_reg, oe_next;
  logic [2:0]              idx_reg, idx_next;
  logic [1:0]              ch_reg, ch_next;
  logic [NUM_RX-1:0]       rx_mask_reg, rx_mask_next;
  logic [NUM_RX-1:0]       act_mask_reg, act_mask_next;
  logic [NUM_RX*SW-1:0]    snap_i_reg, snap_q_reg;
  logic [2*SW-9:0]         tx_sh_reg, tx_sh_next;
  logic [SW-1:0]           tx_i_reg, tx_i_next, tx_q_reg, tx_q_next;
  logic                    tx_valid_reg, tx_valid_next;
  logic                    ovr_reg, ovr_next;
  logic                    stale_reg, stale_next;
  logic [1:0]              rv_cnt_reg, rv_cnt_next;

  logic                    snap_en;      // capture RX_I/RX_Q this cycle
  logic                    frame_snap;   // snapshot at a frame boundary
  logic                    status_clr;   // status byte 0 loaded this cycle
  logic                    frame_end;
  logic [NUM_RX-1:0]       entry_mask;
  logic [2*SW-1:0]         tx_full;
  logic [1:0]              cnt_eff;
  logic [3:0]              mask4;
  logic [7:0]              status0, status1, status2;

  // An empty mask streams channel 0 alone.
  assign entry_mask = (rx_mask_reg == '0) ? MASK_ONE : rx_mask_reg;
  assign frame_end  = (idx_reg == IDX_LAST) && is_last(act_mask_reg, ch_reg);
  assign tx_full    = {tx_sh_reg, DATA_BUS_IN};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mask4
      if (gi < NUM_RX) begin : g_bit
        assign mask4[gi] = rx_mask_reg[gi];
      end else begin : g_pad
        assign mask4[gi] = 1'b0;
      end
    end
  endgenerate

  assign status0 = {6'b0, stale_reg, ovr_reg};
  assign status1 = {4'b0, mask4};
  assign status2 = {NRX4, SB4};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic (DATA_SYNC preempts every state)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (DATA_SYNC) begin
      state_next = decode_cmd(DATA_BUS_IN);
    end else begin
      case (state_reg)
        S_TEST_RD:  state_next = S_TEST_WR;
        S_TEST_WR:  state_next = S_TEST_RD;
        S_TX_RCV:   if (idx_reg == IDX_LAST) state_next = S_IDLE;
        S_SET_MASK: state_next = S_IDLE;
        S_STATUS:   if (idx_reg == 3'd2) state_next = S_IDLE;
        default:    state_next = state_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output / datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    data_out_next = data_out_reg;
    oe_next       = oe_reg;
    idx_next      = idx_reg;
    ch_next       = ch_reg;
    rx_mask_next  = rx_mask_reg;
    act_mask_next = act_mask_reg;
    tx_sh_next    = tx_sh_reg;
    tx_i_next     = tx_i_reg;
    tx_q_next     = tx_q_reg;
    tx_valid_next = 1'b0;
    snap_en       = 1'b0;
    frame_snap    = 1'b0;
    status_clr    = 1'b0;

    if (DATA_SYNC) begin
      idx_next = 3'd0;
      case (DATA_BUS_IN)
        CMD_RX: begin
          // The mask is frozen here, so a later 0x09 only affects the next stream.
          oe_next       = 1'b1;
          snap_en       = 1'b1;
          act_mask_next = entry_mask;
          ch_next       = first_en(entry_mask);
          data_out_next = pick_byte(RX_I, RX_Q, first_en(entry_mask), 3'd0);
        end
        CMD_STATUS: begin
          // Flags are read and cleared on the same edge, so no event is lost.
          oe_next       = 1'b1;
          data_out_next = status0;
          status_clr    = 1'b1;
        end
        default: oe_next = 1'b0;
      endcase
    end else begin
      case (state_reg)
        S_TEST_RD: begin
          data_out_next = DATA_BUS_IN;
          oe_next       = 1'b1;
        end
        S_TEST_WR: oe_next = 1'b0;
        S_TX_RCV: begin
          if (idx_reg == IDX_LAST) begin
            tx_q_next     = tx_full[2*SW-1:SW];
            tx_i_next     = tx_full[SW-1:0];
            tx_valid_next = 1'b1;
            idx_next      = 3'd0;
          end else begin
            tx_sh_next = tx_full[2*SW-9:0];
            idx_next   = idx_reg + 3'd1;
          end
        end
        S_SET_MASK: rx_mask_next = DATA_BUS_IN[NUM_RX-1:0];
        S_RX_STREAM: begin
          if (frame_end) begin
            // The last byte is on the bus. Take a fresh snapshot now, and
            // preload the next frame's first byte straight from the live inputs.
            snap_en       = 1'b1;
            frame_snap    = 1'b1;
            ch_next       = first_en(act_mask_reg);
            idx_next      = 3'd0;
            data_out_next = pick_byte(RX_I, RX_Q, first_en(act_mask_reg), 3'd0);
          end else if (idx_reg == IDX_LAST) begin
            ch_next       = next_en(act_mask_reg, ch_reg);
            idx_next      = 3'd0;
            data_out_next = pick_byte(snap_i_reg, snap_q_reg, next_en(act_mask_reg, ch_reg), 3'd0);
          end else begin
            idx_next      = idx_reg + 3'd1;
            data_out_next = pick_byte(snap_i_reg, snap_q_reg, ch_reg, idx_reg + 3'd1);
          end
        end
        S_STATUS: begin
          case (idx_reg)
            3'd0: begin
              data_out_next = status1;
              idx_next      = 3'd1;
            end
            3'd1: begin
              data_out_next = status2;
              idx_next      = 3'd2;
            end
            default: begin
              oe_next  = 1'b0;
              idx_next = 3'd0;
            end
          endcase
        end
        default: oe_next = 1'b0;
      endcase
    end
  end

  // rx_valid strobes seen since the last snapshot, saturating at 2. A strobe
  // in the snapshot cycle belongs to the sample being captured. The entry
  // snapshot starts a fresh interval, so only frame snapshots judge the
  // overrun and stale conditions.
  assign cnt_eff     = (rv_cnt_reg == 2'd2) ? 2'd2 : (rv_cnt_reg + {1'b0, rx_valid});
  assign rv_cnt_next = snap_en ? 2'd0 : cnt_eff;
  assign ovr_next    = (frame_snap && (cnt_eff == 2'd2)) | (ovr_reg & ~status_clr);
  assign stale_next  = (frame_snap && (cnt_eff == 2'd0)) | (stale_reg & ~status_clr);

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      data_out_reg <= '0;
      oe_reg       <= 1'b0;
      idx_reg      <= '0;
      ch_reg       <= '0;
      rx_mask_reg  <= '1;
      act_mask_reg <= '1;
      snap_i_reg   <= '0;
      snap_q_reg   <= '0;
      tx_sh_reg    <= '0;
      tx_i_reg     <= '0;
      tx_q_reg     <= '0;
      tx_valid_reg <= 1'b0;
      ovr_reg      <= 1'b0;
      stale_reg    <= 1'b0;
      rv_cnt_reg   <= '0;
    end else begin
      data_out_reg <= data_out_next;
      oe_reg       <= oe_next;
      idx_reg      <= idx_next;
      ch_reg       <= ch_next;
      rx_mask_reg  <= rx_mask_next;
      act_mask_reg <= act_mask_next;
      if (snap_en) begin
        snap_i_reg <= RX_I;
        snap_q_reg <= RX_Q;
      end
      tx_sh_reg    <= tx_sh_next;
      tx_i_reg     <= tx_i_next;
      tx_q_reg     <= tx_q_next;
      tx_valid_reg <= tx_valid_next;
      ovr_reg      <= ovr_next;
      stale_reg    <= stale_next;
      rv_cnt_reg   <= rv_cnt_next;
    end
  end

  assign DATA_BUS_OUT = data_out_reg;
  assign DATA_BUS_OE  = oe_reg;
  assign TX_I         = tx_i_reg;
  assign TX_Q         = tx_q_reg;
  assign tx_iq_valid  = tx_valid_reg;
  assign iq_overrun   = ovr_reg;
  assign state_debug  = state_reg;

endmodule

// File: tb/tb_stm32_iq_link.sv
// -----------------------------------------------------------------------------
// tb_stm32_iq_link -- self-checking bench for stm32_iq_link (defaults: 2 RX
// channels, 3-byte samples). A behavioural model keeps the expected RX frame
// as a byte queue built from the enabled channel list, plus the overrun/stale
// flags and the mask as plain variables.
// -----------------------------------------------------------------------------
module tb_stm32_iq_link;

  localparam int NUM_RX = 2;
  localparam int SB     = 3;
  localparam int SW     = 8 * SB;

  logic                 clk_in      = 1'b0;
  logic                 reset_n     = 1'b0;
  logic                 DATA_SYNC   = 1'b0;
  logic [7:0]           DATA_BUS_IN = 8'h00;
  logic [7:0]           DATA_BUS_OUT;
  logic                 DATA_BUS_OE;
  logic [NUM_RX*SW-1:0] RX_I = '0;
  logic [NUM_RX*SW-1:0] RX_Q = '0;
  logic                 rx_valid = 1'b0;
  logic [SW-1:0]        TX_I, TX_Q;
  logic                 tx_iq_valid;
  logic                 iq_overrun;
  logic [3:0]           state_debug;

  stm32_iq_link #(.NUM_RX(NUM_RX), .SAMPLE_BYTES(SB)) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .DATA_SYNC   (DATA_SYNC),
    .DATA_BUS_IN (DATA_BUS_IN),
    .DATA_BUS_OUT(DATA_BUS_OUT),
    .DATA_BUS_OE (DATA_BUS_OE),
    .RX_I        (RX_I),
    .RX_Q        (RX_Q),
    .rx_valid    (rx_valid),
    .TX_I        (TX_I),
    .TX_Q        (TX_Q),
    .tx_iq_valid (tx_iq_valid),
    .iq_overrun  (iq_overrun),
    .state_debug (state_debug)
  );

  always #5 clk_in = ~clk_in;

  int checks    = 0;
  int errors    = 0;
  int pulse_cnt = 0;

  always @(negedge clk_in) if (tx_iq_valid) pulse_cnt++;

  // Reference model state
  logic [NUM_RX-1:0] m_mask  = '1;
  logic              m_ovr   = 1'b0;
  logic              m_stale = 1'b0;
  int                m_rv    = 0;
  logic [7:0]        frame[$];

  typedef struct {
    logic [47:0] bytes;
    logic [23:0] exp_q;
    logic [23:0] exp_i;
  } tx_vec_t;

  typedef struct {
    logic [7:0] mask_byte;
    logic [7:0] exp_b1;
  } mask_vec_t;

  tx_vec_t   tx_tab[8];
  mask_vec_t mask_tab[6];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] c);
    DATA_SYNC   = 1'b1;
    DATA_BUS_IN = c;
    tick();
    DATA_SYNC   = 1'b0;
    DATA_BUS_IN = 8'h00;
  endtask

  // Frame = enabled channels ascending, each Q then I, MSB first.
  function automatic void build_frame(input logic [NUM_RX-1:0] m);
    logic [SW-1:0] q, i;
    frame.delete();
    for (int c = 0; c < NUM_RX; c++) begin
      if (m[c]) begin
        q = RX_Q[c*SW +: SW];
        i = RX_I[c*SW +: SW];
        for (int k = SB - 1; k >= 0; k--) frame.push_back(q[k*8 +: 8]);
        for (int k = SB - 1; k >= 0; k--) frame.push_back(i[k*8 +: 8]);
      end
    end
  endfunction

  task automatic randomize_rx();
    RX_I = 48'({$urandom(), $urandom()});
    RX_Q = 48'({$urandom(), $urandom()});
  endtask

  task automatic do_tx(input tx_vec_t v, input int vi);
    int p0;
    p0 = pulse_cnt;
    send_cmd(8'h03);
    check("tx state rcv", state_debug, 4'd3);
    for (int k = 5; k >= 0; k--) begin
      DATA_BUS_IN = v.bytes[k*8 +: 8];
      tick();
    end
    DATA_BUS_IN = 8'h00;
    check("tx q", TX_Q, v.exp_q);
    check("tx i", TX_I, v.exp_i);
    check("tx valid hi", tx_iq_valid, 1'b1);
    check("tx state idle", state_debug, 4'd0);
    tick();
    check("tx valid lo", tx_iq_valid, 1'b0);
    check("tx pulse count", pulse_cnt, p0 + 1);
    $display("tx vec %0d bytes=%012h Q=%06h I=%06h", vi, v.bytes, TX_Q, TX_I);
  endtask

  // vmode: 0 no rx_valid, 1 random rx_valid, 2 three strobes per frame
  task automatic rx_run(input int ncyc, input int vmode, input bit fixed, input string tag);
    logic [NUM_RX-1:0] eff;
    int pos;
    eff = (m_mask == '0) ? NUM_RX'(1) : m_mask;
    if (!fixed) randomize_rx();
    rx_valid = 1'b0;
    build_frame(eff);
    send_cmd(8'h04);
    m_rv = 0;
    pos  = 0;
    for (int n = 0; n < ncyc; n++) begin
      check("rx byte", DATA_BUS_OUT, frame[pos]);
      check("rx oe", DATA_BUS_OE, 1'b1);
      if (!fixed) randomize_rx();
      case (vmode)
        1:       rx_valid = ($urandom_range(0, 3) == 0);
        2:       rx_valid = (pos == 1) || (pos == 3) || (pos == 5);
        default: rx_valid = 1'b0;
      endcase
      if (rx_valid) m_rv++;
      if (pos == frame.size() - 1) begin
        if (m_rv >= 2) m_ovr = 1'b1;
        if (m_rv == 0) m_stale = 1'b1;
        m_rv = 0;
        build_frame(eff);
        pos = 0;
      end else begin
        pos++;
      end
      tick();
    end
    rx_valid = 1'b0;
    $display("rx run %s mask=%0h frame_len=%0d cycles=%0d", tag, eff, frame.size(), ncyc);
  endtask

  task automatic do_status(input logic [7:0] exp_b1, input string tag);
    logic [7:0] exp_b0;
    exp_b0 = {6'b0, m_stale, m_ovr};
    send_cmd(8'h0A);
    check("st state", state_debug, 4'd6);
    check("st oe", DATA_BUS_OE, 1'b1);
    check("st byte0", DATA_BUS_OUT, exp_b0);
    m_ovr   = 1'b0;
    m_stale = 1'b0;
    tick();
    check("st byte1", DATA_BUS_OUT, exp_b1);
    check("st ovr cleared", iq_overrun, 1'b0);
    tick();
    check("st byte2", DATA_BUS_OUT, 8'h23);
    tick();
    check("st oe off", DATA_BUS_OE, 1'b0);
    check("st idle", state_debug, 4'd0);
    $display("status %s byte0=%02h byte1=%02h", tag, exp_b0, exp_b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r0, r1;
    logic [23:0] tx_q_keep, tx_i_keep;
    logic [7:0]  exp37[12];
    int          p0;

    // ---------------- tables ----------------
    tx_tab[0] = '{48'h112233_445566, 24'h112233, 24'h445566};
    tx_tab[1] = '{48'h800000_7FFFFF, 24'h800000, 24'h7FFFFF};
    tx_tab[2] = '{48'hFFFFFF_000000, 24'hFFFFFF, 24'h000000};
    tx_tab[3] = '{48'h000001_FFFFFE, 24'h000001, 24'hFFFFFE};
    for (int k = 4; k < 8; k++) begin
      r0 = $urandom();
      r1 = $urandom();
      tx_tab[k].bytes = {r0, r1[15:0]};
      tx_tab[k].exp_q = r0[31:8];
      tx_tab[k].exp_i = {r0[7:0], r1[15:0]};
    end
    mask_tab[0] = '{8'h02, 8'h02};
    mask_tab[1] = '{8'h00, 8'h00};
    mask_tab[2] = '{8'hFE, 8'h02};
    mask_tab[3] = '{8'h01, 8'h01};
    mask_tab[4] = '{8'hFF, 8'h03};
    mask_tab[5] = '{8'hFD, 8'h01};
    exp37 = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3,
              8'hC1, 8'hC2, 8'hC3, 8'hD1, 8'hD2, 8'hD3};

    // ---------------- reset ----------------
    reset_n = 1'b0;
    tick(); tick(); tick();
    check("rst state", state_debug, 4'd0);
    check("rst oe", DATA_BUS_OE, 1'b0);
    check("rst bus", DATA_BUS_OUT, 8'h00);
    check("rst tx_i", TX_I, 24'h0);
    check("rst tx_q", TX_Q, 24'h0);
    check("rst valid", tx_iq_valid, 1'b0);
    check("rst ovr", iq_overrun, 1'b0);
    reset_n = 1'b1;
    tick();
    $display("reset done");

    // ---------------- TX table ----------------
    for (int k = 0; k < 8; k++) do_tx(tx_tab[k], k);

    // ---------------- TX abort + bus echo ----------------
    tx_q_keep = tx_tab[7].exp_q;
    tx_i_keep = tx_tab[7].exp_i;
    p0 = pulse_cnt;
    send_cmd(8'h03);
    DATA_BUS_IN = 8'hAA; tick();
    DATA_BUS_IN = 8'hBB; tick();
    DATA_BUS_IN = 8'hCC; tick();
    send_cmd(8'h00);
    check("abort state test_rd", state_debug, 4'd1);
    check("abort oe", DATA_BUS_OE, 1'b0);
    check("abort tx_q", TX_Q, tx_q_keep);
    check("abort tx_i", TX_I, tx_i_keep);
    DATA_BUS_IN = 8'h5A;
    tick();
    check("echo state wr", state_debug, 4'd2);
    check("echo oe", DATA_BUS_OE, 1'b1);
    check("echo byte", DATA_BUS_OUT, 8'h5A);
    DATA_BUS_IN = 8'h3C;
    tick();
    check("echo state rd", state_debug, 4'd1);
    check("echo oe off", DATA_BUS_OE, 1'b0);
    tick();
    check("echo byte2", DATA_BUS_OUT, 8'h3C);
    check("echo oe2", DATA_BUS_OE, 1'b1);
    check("abort no pulse", pulse_cnt, p0);
    $display("tx abort and bus echo");

    // ---------------- RX fixed frame, literal expectation ----------------
    RX_Q = {24'hC1C2C3, 24'hA1A2A3};
    RX_I = {24'hD1D2D3, 24'hB1B2B3};
    rx_valid = 1'b0;
    send_cmd(8'h04);
    for (int k = 0; k < 24; k++) begin
      check("rx37 byte", DATA_BUS_OUT, exp37[k % 12]);
      check("rx37 oe", DATA_BUS_OE, 1'b1);
      tick();
    end
    m_stale = 1'b1;   // two frame snapshots with no rx_valid in between
    $display("rx fixed frame 24 bytes");
    do_status({6'b0, m_mask}, "after fixed rx");

    // ---------------- overrun: three strobes per frame ----------------
    rx_run(36, 2, 1'b1, "overrun");
    check("ovr pin set", iq_overrun, 1'b1);
    do_status({6'b0, m_mask}, "overrun 1st");
    do_status({6'b0, m_mask}, "overrun 2nd");

    // ---------------- random RX streams, all channels ----------------
    for (int k = 0; k < 3; k++) begin
      rx_run(40, 1, 1'b0, "random");
      do_status({6'b0, m_mask}, "random");
    end

    // ---------------- mask table ----------------
    for (int k = 0; k < 6; k++) begin
      send_cmd(8'h09);
      DATA_BUS_IN = mask_tab[k].mask_byte;
      tick();
      DATA_BUS_IN = 8'h00;
      check("mask idle", state_debug, 4'd0);
      check("mask oe", DATA_BUS_OE, 1'b0);
      m_mask = mask_tab[k].mask_byte[NUM_RX-1:0];
      rx_run(30, 1, 1'b0, "masked");
      do_status(mask_tab[k].exp_b1, "masked");
    end

    // ---------------- reset mid-stream, with DATA_SYNC asserted ----------------
    rx_run(10, 1, 1'b0, "pre-reset");
    p0 = pulse_cnt;
    reset_n     = 1'b0;
    DATA_SYNC   = 1'b1;
    DATA_BUS_IN = 8'h03;
    tick();
    check("mid rst state", state_debug, 4'd0);
    check("mid rst oe", DATA_BUS_OE, 1'b0);
    check("mid rst bus", DATA_BUS_OUT, 8'h00);
    check("mid rst tx_i", TX_I, 24'h0);
    check("mid rst tx_q", TX_Q, 24'h0);
    check("mid rst valid", tx_iq_valid, 1'b0);
    check("mid rst ovr", iq_overrun, 1'b0);
    reset_n     = 1'b1;
    DATA_SYNC   = 1'b0;
    DATA_BUS_IN = 8'h00;
    m_mask  = '1;
    m_ovr   = 1'b0;
    m_stale = 1'b0;
    tick();
    check("post rst idle", state_debug, 4'd0);
    check("post rst no pulse", pulse_cnt, p0);
    $display("reset mid-stream");
    do_status(8'h03, "after reset");
    do_tx(tx_tab[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
